// File: rtl/i2c_master_controller.sv
// Byte-oriented I2C master: single-register write/read with open-drain SCL/SDA enables.
// Optional clock stretching is enabled with `define I2C_MASTER_CLK_STRETCH_EN.
module i2c_master_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StAddrAck, StReg, StRegAck, StWdata, StWdataAck,
    StRstart, StRaddr, StRaddrAck, StRdata, StMnack, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic            rw_q, rw_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdat_q, wdat_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            smp_q, smp_d;
  logic            ack_err_q, ack_err_d;
  logic            done_q, done_d;
  logic            stall;
  logic [7:0]      tx_byte;

`ifdef I2C_MASTER_CLK_STRETCH_EN
  // SCL is always released in q2/q3, so a low pad level there means the target is stretching.
  assign stall = (state_q != StIdle) && qtr_q[1] && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd7;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wdat_q    <= 8'd0;
      shift_q   <= 8'd0;
      rd_data_q <= 8'd0;
      smp_q     <= 1'b1;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdat_q    <= wdat_d;
      shift_q   <= shift_d;
      rd_data_q <= rd_data_d;
      smp_q     <= smp_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdat_d    = wdat_q;
    shift_d   = shift_q;
    rd_data_d = rd_data_q;
    smp_d     = smp_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    if (state_q == StIdle) begin
      div_d = '0;
      qtr_d = 2'd0;
      bit_d = 3'd7;
      if (start) begin
        rw_d      = rw;
        dev_d     = dev_addr;
        reg_d     = reg_addr;
        wdat_d    = wr_data;
        ack_err_d = 1'b0;
        state_d   = StStart;
      end
    end else if (!stall) begin
      if (qtr_q == 2'd3 && div_q == '0) begin
        smp_d = sda_in;
        if (state_q == StRdata) shift_d = {shift_q[6:0], sda_in};
      end
      if (div_q != DivMax) begin
        div_d = div_q + DivW'(1);
      end else begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          bit_d = 3'd7;
          case (state_q)
            StStart:    state_d = StAddr;
            StAddr:     if (bit_q == 3'd0) state_d = StAddrAck; else bit_d = bit_q - 3'd1;
            StReg:      if (bit_q == 3'd0) state_d = StRegAck; else bit_d = bit_q - 3'd1;
            StWdata:    if (bit_q == 3'd0) state_d = StWdataAck; else bit_d = bit_q - 3'd1;
            StRaddr:    if (bit_q == 3'd0) state_d = StRaddrAck; else bit_d = bit_q - 3'd1;
            StRdata: begin
              if (bit_q == 3'd0) begin
                state_d   = StMnack;
                rd_data_d = shift_d;
              end else begin
                bit_d = bit_q - 3'd1;
              end
            end
            StAddrAck, StRegAck, StWdataAck, StRaddrAck: begin
              if (smp_d) begin
                ack_err_d = 1'b1;
                state_d   = StStop;
              end else if (state_q == StAddrAck) begin
                state_d = StReg;
              end else if (state_q == StRegAck) begin
                state_d = rw_q ? StRstart : StWdata;
              end else if (state_q == StRaddrAck) begin
                state_d = StRdata;
              end else begin
                state_d = StStop;
              end
            end
            StRstart:   state_d = StRaddr;
            StMnack:    state_d = StStop;
            StStop: begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
            default:    state_d = StIdle;
          endcase
        end
      end
    end
  end

  always_comb begin
    tx_byte = 8'hFF;
    scl_oe  = 1'b0;
    sda_oe  = 1'b0;
    case (state_q)
      StAddr:  tx_byte = {dev_q, 1'b0};
      StReg:   tx_byte = reg_q;
      StWdata: tx_byte = wdat_q;
      StRaddr: tx_byte = {dev_q, 1'b1};
      default: tx_byte = 8'hFF;
    endcase
    case (state_q)
      StIdle:  ;
      StStart: sda_oe = qtr_q[1];
      StAddr, StReg, StWdata, StRaddr: begin
        scl_oe = !qtr_q[1];
        sda_oe = !tx_byte[bit_q];
      end
      StRstart: begin
        scl_oe = !qtr_q[1];
        sda_oe = (qtr_q == 2'd3);
      end
      StStop: begin
        scl_oe = !qtr_q[1];
        sda_oe = (qtr_q != 2'd3);
      end
      default: scl_oe = !qtr_q[1];
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Directed bench for i2c_master_controller with a bus-level I2C target model and
// START/STOP protocol monitor.
module tb_i2c_master_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'd0;
  logic [7:0] reg_addr = 8'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] rd_data;
  logic       busy, done, ack_err, scl_oe, sda_oe, scl_in, sda_in;

  logic slv_scl = 1'b0;
  logic slv_sda = 1'b0;
  logic slv_clr = 1'b0;
  logic ack_en = 1'b1;
  logic stretch_en = 1'b0;
  logic [7:0] rdval = 8'h00;

  int cmp = 0;
  int mis = 0;

  // Target model state, owned by the monitor process.
  logic [7:0] bytes[$];
  logic [7:0] shreg = 8'd0;
  int   bitcnt = 0, nbyte = 0, rises = 0, hold = 0;
  logic sending = 1'b0, snext = 1'b0, in_frame = 1'b0, mack = 1'b0;
  logic sc_p = 1'b1, sd_p = 1'b1, oe_p = 1'b0, cs, ds;
  int   start_cnt = 0, restart_cnt = 0, stop_cnt = 0, done_cnt = 0;

  assign scl_in = ~(scl_oe | slv_scl);
  assign sda_in = ~(sda_oe | slv_sda);

  always #5 clk = ~clk;

  i2c_master_controller #(.CLK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rw       (rw),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .scl_in   (scl_in),
    .sda_in   (sda_in)
  );

  always @(negedge clk) begin
    if (slv_clr) begin
      bytes.delete();
      bitcnt = 0; nbyte = 0; rises = 0; hold = 0;
      sending = 1'b0; snext = 1'b0; in_frame = 1'b0; mack = 1'b0;
      slv_scl = 1'b0; slv_sda = 1'b0;
      oe_p = scl_oe; sc_p = scl_in; sd_p = sda_in;
    end else begin
      if (stretch_en) begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) slv_scl = 1'b0;
        end else if (oe_p && !scl_oe) begin
          rises++;
          if (rises == 9) begin
            slv_scl = 1'b1;
            hold = 37;
          end
        end
      end
      oe_p = scl_oe;
      cs = !(scl_oe || slv_scl);
      ds = !(sda_oe || slv_sda);
      if (cs && sc_p && (ds != sd_p)) begin
        if (!ds) begin
          if (in_frame) restart_cnt++; else start_cnt++;
          in_frame = 1'b1;
        end else begin
          stop_cnt++;
          in_frame = 1'b0;
          slv_sda = 1'b0;
        end
        bitcnt = 0; nbyte = 0; sending = 1'b0; snext = 1'b0;
      end else if (cs && !sc_p) begin
        if (bitcnt < 8) begin
          if (!sending) shreg = {shreg[6:0], ds};
          bitcnt++;
        end else if (bitcnt == 8) begin
          if (sending) begin
            mack = ds;
            if (ds) snext = 1'b0;
          end
          bitcnt = 9;
        end
      end else if (!cs && sc_p) begin
        if (bitcnt == 8) begin
          if (!sending) begin
            bytes.push_back(shreg);
            slv_sda = ack_en;
            if (nbyte == 0) snext = shreg[0];
            nbyte++;
          end else begin
            slv_sda = 1'b0;
          end
        end else if (bitcnt == 9) begin
          bitcnt = 0;
          sending = snext;
          slv_sda = snext ? !rdval[7] : 1'b0;
        end else if (sending && in_frame) begin
          slv_sda = !rdval[7-bitcnt];
        end
      end
      sc_p = cs;
      sd_p = ds;
      if (done) done_cnt++;
    end
  end

  task automatic clear_slave();
    @(posedge clk); #1 slv_clr = 1'b1;
    @(posedge clk); #1 slv_clr = 1'b0;
  endtask

  task automatic do_txn(input logic r, input logic [6:0] da, input logic [7:0] ra,
                        input logic [7:0] wd, input int glitch_at,
                        output int lat, output bit to);
    @(posedge clk); #1;
    rw = r; dev_addr = da; reg_addr = ra; wr_data = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == glitch_at) begin
        start = 1'b1; rw = ~r; reg_addr = 8'h77; wr_data = 8'h11;
      end else if (i == glitch_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp++; if ({scl_oe, sda_oe} !== 2'b00) begin mis++; $display("FAIL reset_oe: got %b expected 00", {scl_oe, sda_oe}); end
    cmp++; if ({busy, done, ack_err} !== 3'b000) begin mis++; $display("FAIL reset_flags: got %b expected 000", {busy, done, ack_err}); end
    cmp++; if (rd_data !== 8'h00) begin mis++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    rst = 1'b0;
    clear_slave();
  endtask

  task automatic test_write();
    int lat; bit to; int s0, p0, r0;
    ack_en = 1'b1;
    s0 = start_cnt; p0 = stop_cnt; r0 = restart_cnt;
    do_txn(1'b0, 7'h2A, 8'h03, 8'hA5, -1, lat, to);
    cmp++; if (to || lat != 464) begin mis++; $display("FAIL write_latency: got %0d (timeout %0d) expected 464", lat, to); end
    cmp++; if (ack_err !== 1'b0) begin mis++; $display("FAIL write_ack_err: got %b expected 0", ack_err); end
    cmp++; if (busy !== 1'b0) begin mis++; $display("FAIL write_busy_at_done: got %b expected 0", busy); end
    repeat (4) @(posedge clk); #1;
    cmp++; if (bytes.size() != 3 || bytes[0] !== 8'h54 || bytes[1] !== 8'h03 || bytes[2] !== 8'hA5) begin
      mis++; $display("FAIL write_bytes: got n=%0d %p expected 54 03 a5", bytes.size(), bytes);
    end
    cmp++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1 || restart_cnt - r0 != 0) begin
      mis++; $display("FAIL write_protocol: got start=%0d stop=%0d restart=%0d expected 1 1 0",
                      start_cnt - s0, stop_cnt - p0, restart_cnt - r0);
    end
    clear_slave();
  endtask

  task automatic test_read();
    int lat; bit to; int s0, p0, r0;
    ack_en = 1'b1;
    rdval = 8'h5C;
    s0 = start_cnt; p0 = stop_cnt; r0 = restart_cnt;
    do_txn(1'b1, 7'h2A, 8'h03, 8'h00, -1, lat, to);
    cmp++; if (to || lat != 624) begin mis++; $display("FAIL read_latency: got %0d (timeout %0d) expected 624", lat, to); end
    cmp++; if (rd_data !== 8'h5C) begin mis++; $display("FAIL read_data: got %h expected 5c", rd_data); end
    cmp++; if (ack_err !== 1'b0) begin mis++; $display("FAIL read_ack_err: got %b expected 0", ack_err); end
    repeat (4) @(posedge clk); #1;
    cmp++; if (bytes.size() != 3 || bytes[0] !== 8'h54 || bytes[1] !== 8'h03 || bytes[2] !== 8'h55) begin
      mis++; $display("FAIL read_bytes: got n=%0d %p expected 54 03 55", bytes.size(), bytes);
    end
    cmp++; if (mack !== 1'b1) begin mis++; $display("FAIL read_master_nack: got %b expected 1", mack); end
    cmp++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1 || restart_cnt - r0 != 1) begin
      mis++; $display("FAIL read_protocol: got start=%0d stop=%0d restart=%0d expected 1 1 1",
                      start_cnt - s0, stop_cnt - p0, restart_cnt - r0);
    end
    clear_slave();
  endtask

  task automatic test_addr_nack();
    int lat; bit to; int p0;
    ack_en = 1'b0;
    p0 = stop_cnt;
    do_txn(1'b1, 7'h2A, 8'h03, 8'h00, -1, lat, to);
    cmp++; if (to || lat != 176) begin mis++; $display("FAIL nack_latency: got %0d (timeout %0d) expected 176", lat, to); end
    cmp++; if (ack_err !== 1'b1) begin mis++; $display("FAIL nack_ack_err: got %b expected 1", ack_err); end
    cmp++; if (rd_data !== 8'h5C) begin mis++; $display("FAIL nack_rd_data_kept: got %h expected 5c", rd_data); end
    repeat (4) @(posedge clk); #1;
    cmp++; if (stop_cnt - p0 != 1 || bytes.size() != 1) begin
      mis++; $display("FAIL nack_stop: got stops=%0d bytes=%0d expected 1 1", stop_cnt - p0, bytes.size());
    end
    ack_en = 1'b1;
    clear_slave();
  endtask

  task automatic test_start_ignored();
    int lat; bit to; int d0;
    d0 = done_cnt;
    do_txn(1'b0, 7'h2A, 8'h03, 8'hA5, 100, lat, to);
    cmp++; if (to || lat != 464) begin mis++; $display("FAIL ignore_latency: got %0d (timeout %0d) expected 464", lat, to); end
    cmp++; if (ack_err !== 1'b0) begin mis++; $display("FAIL ignore_ack_err: got %b expected 0", ack_err); end
    repeat (700) @(posedge clk); #1;
    cmp++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      mis++; $display("FAIL ignore_single_done: got dones=%0d busy=%b expected 1 0", done_cnt - d0, busy);
    end
    cmp++; if (bytes.size() != 3 || bytes[1] !== 8'h03 || bytes[2] !== 8'hA5) begin
      mis++; $display("FAIL ignore_bytes: got n=%0d %p expected 54 03 a5", bytes.size(), bytes);
    end
    clear_slave();
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    rw = 1'b0; dev_addr = 7'h2A; reg_addr = 8'h03; wr_data = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (191) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    cmp++; if ({scl_oe, sda_oe, busy} !== 3'b000) begin
      mis++; $display("FAIL rst_mid_release: got scl_oe,sda_oe,busy=%b expected 000", {scl_oe, sda_oe, busy});
    end
    rst = 1'b0;
    repeat (600) @(posedge clk); #1;
    cmp++; if (done_cnt != d0 || busy !== 1'b0) begin
      mis++; $display("FAIL rst_mid_no_done: got dones=%0d busy=%b expected 0 0", done_cnt - d0, busy);
    end
    clear_slave();
  endtask

`ifdef I2C_MASTER_CLK_STRETCH_EN
  task automatic test_stretch();
    int lat; bit to;
    ack_en = 1'b1;
    stretch_en = 1'b1;
    do_txn(1'b0, 7'h2A, 8'h03, 8'hA5, -1, lat, to);
    cmp++; if (to || lat != 501) begin mis++; $display("FAIL stretch_latency: got %0d (timeout %0d) expected 501", lat, to); end
    cmp++; if (ack_err !== 1'b0) begin mis++; $display("FAIL stretch_ack_err: got %b expected 0", ack_err); end
    repeat (4) @(posedge clk); #1;
    cmp++; if (bytes.size() != 3 || bytes[0] !== 8'h54 || bytes[1] !== 8'h03 || bytes[2] !== 8'hA5) begin
      mis++; $display("FAIL stretch_bytes: got n=%0d %p expected 54 03 a5", bytes.size(), bytes);
    end
    stretch_en = 1'b0;
    clear_slave();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_start_ignored();
    test_reset_mid();
`ifdef I2C_MASTER_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
